mx_block_aligner: RTL



---
 rtl/mx_pkg.sv | 21 ++
 rtl/mx_elem_aligner.sv | 46 ++++
 rtl/mx_block_aligner.sv | 105 ++++++++++
 3 files changed

// File: rtl/mx_pkg.sv
// Shared constants, bf16 element layout and FSM state type for the MX block aligner.
package mx_pkg;

    localparam int BF16_EXP_W    = 8;
    localparam int BF16_MAN_W    = 7;
    localparam int MX_ELEM_W     = 8;
    localparam int MX_BLOCK_SIZE = 32;
    localparam logic [BF16_EXP_W-1:0] MX_NAN_EXP = 8'hFF;

    typedef struct packed {
        logic                  s;
        logic [BF16_EXP_W-1:0] e;
        logic [BF16_MAN_W-1:0] m;
    } bf16_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/mx_elem_aligner.sv
// Combinational bf16 -> MXINT8 element alignment against the block's shared exponent.
// MX_ALIGN_ROUND_EN selects round-to-nearest (ties away) with saturation; default truncates.
module mx_elem_aligner
    import mx_pkg::*;
(
    input  logic                  s,
    input  logic [BF16_EXP_W-1:0] e,
    input  logic [BF16_MAN_W-1:0] m,
    input  logic [BF16_EXP_W-1:0] max_e,
    input  logic                  nan_flag,
    output logic [MX_ELEM_W-1:0]  elem
);

    logic [7:0] full;
    logic [7:0] shift;
    logic [7:0] mag_t;
    logic [7:0] mag;
    logic       rnd;

    always_comb begin
        full  = {1'b1, m};
        shift = max_e - e;
        mag_t = '0;
        rnd   = 1'b0;
        if (shift < 8'd7) begin
            mag_t = full >> (shift + 8'd1);
        end
`ifdef MX_ALIGN_ROUND_EN
        // The round bit is the first bit dropped by the (shift+1) right shift.
        if (shift <= 8'd7) begin
            rnd = full[shift[2:0]];
        end
        mag = mag_t + {7'd0, rnd};
        if (mag > 8'd127) begin
            mag = 8'd127;
        end
`else
        mag = mag_t;
`endif
        elem = '0;
        if (!nan_flag && e != '0) begin
            elem = s ? (8'd0 - mag) : mag;
        end
    end

endmodule

// File: rtl/mx_block_aligner.sv
// Buffers BLOCK_SIZE bf16 elements, then drains them as one MXINT8 block sharing the max exponent.
// Rounding behaviour of the element path is selected by MX_ALIGN_ROUND_EN (see mx_elem_aligner).
module mx_block_aligner
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = MX_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_s,
    input  logic [BF16_EXP_W-1:0] in_e,
    input  logic [BF16_MAN_W-1:0] in_m,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_scale,
    output logic [MX_ELEM_W-1:0]  out_elem,
    output logic                  out_last
);

    localparam int IW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);

    state_t                  state, state_nxt;
    bf16_t                   mem [BLOCK_SIZE];
    logic [IW-1:0]           wr_idx, rd_idx;
    logic [BF16_EXP_W-1:0]   max_e;
    logic                    nan_flag;
    logic                    in_fire, out_fire;
    bf16_t                   rd_ent;
    logic [MX_ELEM_W-1:0]    aligned;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Handshake outputs are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            FILL: begin
                in_ready = rst_n;
                if (rst_n && in_valid && wr_idx == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = rst_n;
                out_last  = rst_n && (rd_idx == LAST_IDX);
                if (rst_n && out_ready && rd_idx == LAST_IDX) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            max_e    <= '0;
            nan_flag <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + 1'b1;
                if (in_e != '0 && in_e > max_e) max_e <= in_e;
                if (in_e == MX_NAN_EXP) nan_flag <= 1'b1;
            end
            if (out_fire) begin
                if (rd_idx == LAST_IDX) begin
                    wr_idx   <= '0;
                    rd_idx   <= '0;
                    max_e    <= '0;
                    nan_flag <= 1'b0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[wr_idx] <= '{s: in_s, e: in_e, m: in_m};
    end

    assign rd_ent = mem[rd_idx];

    mx_elem_aligner u_align (
        .s        (rd_ent.s),
        .e        (rd_ent.e),
        .m        (rd_ent.m),
        .max_e    (max_e),
        .nan_flag (nan_flag),
        .elem     (aligned)
    );

    assign out_elem  = out_valid ? aligned : '0;
    assign out_scale = nan_flag ? MX_NAN_EXP : max_e;

endmodule
